// File: rtl/kbd_cmd_decoder.sv
// PS/2 ASCII code -> player controls (play/pause, direction, restart, speed divider).
// Optional: define KBD_SPACE_TOGGLE_EN to make space (8'h20) toggle play.
module kbd_cmd_decoder #(
  parameter int unsigned DIV_W         = 32,
  parameter int unsigned DEFAULT_DIV   = 1136,
  parameter int unsigned MIN_DIV       = 284,
  parameter int unsigned MAX_DIV       = 4544,
  parameter int unsigned STEP          = 64,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             CLK_50M,
  input  logic             reset,
  input  logic [7:0]       kbd_received_ascii_code,
  output logic             play,
  output logic             reverse,
  output logic             restart,
  output logic [DIV_W-1:0] speed_div,
  output logic             cmd_strobe
);

  localparam logic [7:0]       StableCnt = 8'(STABLE_CYCLES);
  localparam logic [7:0]       FireCnt   = 8'(STABLE_CYCLES - 1);
  localparam logic [DIV_W:0]   StepW     = (DIV_W + 1)'(STEP);
  localparam logic [DIV_W:0]   MinW      = (DIV_W + 1)'(MIN_DIV);
  localparam logic [DIV_W:0]   MaxW      = (DIV_W + 1)'(MAX_DIV);
  localparam logic [DIV_W-1:0] MinDiv    = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] MaxDiv    = DIV_W'(MAX_DIV);
  localparam logic [DIV_W-1:0] DefDiv    = DIV_W'(DEFAULT_DIV);

  logic [7:0]       s1_q, s2_q;
  logic [7:0]       cand_q, cand_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             play_q, play_d;
  logic             reverse_q, reverse_d;
  logic             restart_q, restart_d;
  logic             strobe_q, strobe_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             fire;
  logic [7:0]       key;
  logic [DIV_W:0]   sum, diff;

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      s1_q      <= 8'h00;
      s2_q      <= 8'h00;
      cand_q    <= 8'h00;
      cnt_q     <= StableCnt;
      play_q    <= 1'b0;
      reverse_q <= 1'b0;
      restart_q <= 1'b0;
      strobe_q  <= 1'b0;
      div_q     <= DefDiv;
    end else begin
      s1_q      <= kbd_received_ascii_code;
      s2_q      <= s1_q;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      play_q    <= play_d;
      reverse_q <= reverse_d;
      restart_q <= restart_d;
      strobe_q  <= strobe_d;
      div_q     <= div_d;
    end
  end

  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    play_d    = play_q;
    reverse_d = reverse_q;
    div_d     = div_q;
    restart_d = 1'b0;
    strobe_d  = 1'b0;

    // Fold lower-case letters onto upper case so the map is case-insensitive.
    key = cand_q;
    if (cand_q >= 8'h61 && cand_q <= 8'h7a) key = cand_q - 8'h20;

    // Extra MSB absorbs borrow/carry so saturation compares are exact.
    sum  = {1'b0, div_q} + StepW;
    diff = {1'b0, div_q} - StepW;

    fire = (s2_q == cand_q) && (cnt_q == FireCnt);

    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = 8'h00;
    end else if (cnt_q < StableCnt) begin
      cnt_d = cnt_q + 8'd1;
    end

    if (fire) begin
      strobe_d = 1'b1;
      case (key)
        8'h45: play_d    = 1'b1;
        8'h44: play_d    = 1'b0;
        8'h46: reverse_d = 1'b0;
        8'h42: reverse_d = 1'b1;
        8'h52: restart_d = 1'b1;
        8'h55: div_d     = (diff[DIV_W] || diff < MinW) ? MinDiv : diff[DIV_W-1:0];
        8'h53: div_d     = (sum > MaxW) ? MaxDiv : sum[DIV_W-1:0];
        8'h4e: div_d     = DefDiv;
`ifdef KBD_SPACE_TOGGLE_EN
        8'h20: play_d    = ~play_q;
`endif
        default: strobe_d = 1'b0;
      endcase
    end
  end

  assign play       = play_q;
  assign reverse    = reverse_q;
  assign restart    = restart_q;
  assign speed_div  = div_q;
  assign cmd_strobe = strobe_q;

endmodule

// File: tb/tb_kbd_cmd_decoder.sv
// Scoreboard bench for kbd_cmd_decoder: expected command effects are queued at drive time
// and checked when cmd_strobe fires.
module tb_kbd_cmd_decoder;

  localparam int unsigned DIV_W  = 32;
  localparam int unsigned DEF    = 1136;
  localparam int unsigned MIN    = 284;
  localparam int unsigned MAX    = 4544;
  localparam int unsigned STEP   = 64;
  localparam int unsigned STABLE = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       kbd;
  logic             play, reverse, restart, cmd_strobe;
  logic [DIV_W-1:0] speed_div;

  kbd_cmd_decoder #(
    .DIV_W(DIV_W), .DEFAULT_DIV(DEF), .MIN_DIV(MIN), .MAX_DIV(MAX), .STEP(STEP),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .CLK_50M                 (clk),
    .reset                   (reset),
    .kbd_received_ascii_code (kbd),
    .play                    (play),
    .reverse                 (reverse),
    .restart                 (restart),
    .speed_div               (speed_div),
    .cmd_strobe              (cmd_strobe)
  );

  always #10 clk = ~clk;

  typedef struct {
    int unsigned      cyc;
    logic             play;
    logic             rev;
    logic             rst;
    logic [DIV_W-1:0] div;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic             m_play, m_rev;
  logic [DIV_W-1:0] m_div;
  logic [7:0]       prev_code;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent reference of the command map.
  task automatic model_cmd(input logic [7:0] code, output bit mapped, output bit is_rst);
    logic [7:0] c;
    c = code;
    if (c >= 8'h61 && c <= 8'h7a) c = c - 8'h20;
    mapped = 1'b1;
    is_rst = 1'b0;
    case (c)
      8'h45: m_play = 1'b1;
      8'h44: m_play = 1'b0;
      8'h46: m_rev  = 1'b0;
      8'h42: m_rev  = 1'b1;
      8'h52: is_rst = 1'b1;
      8'h55: m_div  = (m_div >= MIN + STEP) ? m_div - STEP : MIN;
      8'h53: m_div  = (m_div + STEP <= MAX) ? m_div + STEP : MAX;
      8'h4e: m_div  = DEF;
`ifdef KBD_SPACE_TOGGLE_EN
      8'h20: m_play = ~m_play;
`endif
      default: mapped = 1'b0;
    endcase
  endtask

  task automatic push_exp(input int unsigned at, input bit is_rst);
    exp_t e;
    e.cyc  = at;
    e.play = m_play;
    e.rev  = m_rev;
    e.rst  = is_rst;
    e.div  = m_div;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_state();
    check_eq("play", play, m_play);
    check_eq("reverse", reverse, m_rev);
    check_eq("speed_div", speed_div, m_div);
  endtask

  task automatic model_reset();
    m_play    = 1'b0;
    m_rev     = 1'b0;
    m_div     = DEF;
    prev_code = 8'h00;
  endtask

  // Drive a code for n cycles; a changed code held >= STABLE+1 cycles fires STABLE+3 later.
  task automatic hold(input logic [7:0] code, input int n);
    bit mapped, is_rst;
    kbd = code;
    if (code != prev_code && n >= int'(STABLE) + 1) begin
      model_cmd(code, mapped, is_rst);
      if (mapped) push_exp(cyc + 3 + STABLE, is_rst);
    end
    prev_code = code;
    tick(n);
    if (n >= int'(STABLE) + 3) check_state();
  endtask

  // Scoreboard side: every strobe must match the head of the queue, on the expected cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check_eq("strobe_missing", 0, 1);
      void'(exp_q.pop_front());
    end
    if (cmd_strobe) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("fire_cycle", cyc, e.cyc);
        check_eq("fire_play", play, e.play);
        check_eq("fire_reverse", reverse, e.rev);
        check_eq("fire_restart", restart, e.rst);
        check_eq("fire_div", speed_div, e.div);
      end
    end else if (restart) begin
      check_eq("restart_without_strobe", restart, 0);
    end
  end

  initial begin
    int unsigned n0;
    reset = 1'b1;
    kbd   = 8'h00;
    model_reset();
    tick(3);
    check_eq("rst_play", play, 0);
    check_eq("rst_reverse", reverse, 0);
    check_eq("rst_restart", restart, 0);
    check_eq("rst_strobe", cmd_strobe, 0);
    check_eq("rst_div", speed_div, DEF);
    reset = 1'b0;
    tick(2);

    hold(8'h45, 10);               // 'E'
    hold(8'h62, 10);               // 'b'
    hold(8'h44, 10);               // 'D'

    for (int i = 0; i < 20; i++) begin
      hold(8'h55, 8);              // 'U'
      hold(8'h00, 2);
    end
    hold(8'h4e, 10);               // 'N'
    hold(8'h00, 2);
    for (int i = 0; i < 60; i++) begin
      hold(8'h73, 8);              // 's'
      hold(8'h00, 2);
    end
    hold(8'h52, 10);               // 'R'
    hold(8'h00, 2);

    hold(8'h46, 3);                // 'F' glitch
    hold(8'h42, 10);               // 'B'
    hold(8'h75, 3);                // 'u' glitch
    hold(8'h78, 10);               // unmapped 'x'
    hold(8'h65, 50);               // 'e' held long
    hold(8'h44, 10);
    hold(8'h00, 10);

    // Reset while 'E' is mid-qualification: count discarded, code re-qualifies.
    kbd = 8'h45;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_reset();
    m_play = 1'b1;
    push_exp(cyc + 3 + STABLE, 1'b0);
    prev_code = 8'h45;
    tick(10);
    check_state();
    hold(8'h44, 10);
    hold(8'h00, 10);

    // Reset landing on the fire edge wins; code fires again afterwards.
    kbd = 8'h45;
    n0  = cyc;
    tick(6);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_eq("reset_dominates_fire", {cmd_strobe, play}, 2'b00);
    model_reset();
    m_play = 1'b1;
    push_exp(n0 + 7 + 3 + STABLE, 1'b0);
    prev_code = 8'h45;
    tick(10);
    check_state();

    hold(8'h64, 10);               // 'd'
    hold(8'h00, 10);
    hold(8'h20, 10);
    hold(8'h00, 10);
    hold(8'h20, 10);
    hold(8'h00, 10);

    tick(5);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
